// File: rtl/ctrl_shadow_pkg.sv
// Shared types and constants for the shadowed control register.
package ctrl_shadow_pkg;

    // Sequencer state: idle, or holding the first write of a pair.
    typedef enum logic [0:0] {
        StIdle,
        StStaged
    } ctrl_state_e;

    // Control register layout; MSB first.
    typedef struct packed {
        logic force_zero_masks;
        logic manual_operation;
    } ctrl_reg_t;

    localparam ctrl_reg_t CTRL_RESET = '{force_zero_masks: 1'b1, manual_operation: 1'b0};

endpackage

// File: rtl/ctrl_shadow_timer.sv
// Saturating cycle counter that flags when a staged write has waited too long.
module ctrl_shadow_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Clear wins over enable; hold at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // TIMEOUT of 0 disables expiry entirely.
    assign expired_o = (TIMEOUT > 0) && (cnt_q == CntLast);

endmodule

// File: rtl/ctrl_shadow_seq.sv
// Double-write shadowed control register: a value commits only when written
// twice with identical data; the committed copy is guarded by an inverted shadow.
module ctrl_shadow_seq
    import ctrl_shadow_pkg::*;
#(
    parameter int unsigned     DW      = 2,
    parameter logic [DW-1:0]   RESVAL  = '0,
    parameter int              TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [DW-1:0] wd_i,
    input  logic          re_i,
    output logic [DW-1:0] q_o,
    output logic          qe_o,
    output logic          phase_o,
    output logic          err_update_o,
    output logic          err_storage_o
);

    ctrl_state_e   state_q, state_d;
    logic [DW-1:0] staged_q, staged_d;
    logic [DW-1:0] committed_q, committed_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic          qe_q, qe_d;
    logic          err_update_q, err_update_d;
    logic          err_storage_q, err_storage_d;

    logic we_eff;
    logic tmr_clr, tmr_en, tmr_expired;

    // A storage fault locks out further writes.
    assign we_eff = we_i && !err_storage_q;

    ctrl_shadow_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any write, read or expiry ends a staged sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (we_eff) state_d = StStaged;
            end
            StStaged: begin
                if (we_eff || re_i || tmr_expired) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and flag next values; the write is checked before re_i/expiry.
    always_comb begin
        staged_d      = staged_q;
        committed_d   = committed_q;
        shadow_d      = shadow_q;
        qe_d          = 1'b0;
        err_update_d  = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        err_storage_d = err_storage_q || (committed_q != ~shadow_q);
        unique case (state_q)
            StIdle: begin
                if (we_eff) begin
                    staged_d = wd_i;
                    tmr_clr  = 1'b1;
                end
            end
            StStaged: begin
                if (we_eff) begin
                    if (wd_i == staged_q) begin
                        committed_d = wd_i;
                        shadow_d    = ~wd_i;
                        qe_d        = 1'b1;
                    end else begin
                        err_update_d = 1'b1;
                    end
                end else if (!re_i) begin
                    tmr_en = 1'b1;
                    if (tmr_expired) err_update_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Data and flag registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            staged_q      <= RESVAL;
            committed_q   <= RESVAL;
            shadow_q      <= ~RESVAL;
            qe_q          <= 1'b0;
            err_update_q  <= 1'b0;
            err_storage_q <= 1'b0;
        end else begin
            staged_q      <= staged_d;
            committed_q   <= committed_d;
            shadow_q      <= shadow_d;
            qe_q          <= qe_d;
            err_update_q  <= err_update_d;
            err_storage_q <= err_storage_d;
        end
    end

    assign q_o           = committed_q;
    assign qe_o          = qe_q;
    assign phase_o       = (state_q == StStaged);
    assign err_update_o  = err_update_q;
    assign err_storage_o = err_storage_q;

endmodule

// File: doc/ctrl_shadow_seq.md
CTRL_SHADOW_SEQ -- requirements
Module: ctrl_shadow_seq

Interface
REQ-001 SHALL have parameter DW, default 2: data width of the controlled register.
REQ-002 SHALL have parameter RESVAL (logic [DW-1:0]), default '0: committed reset value, fed from a packed struct constant.
REQ-003 SHALL have parameter TIMEOUT (int), default 16: maximum cycles allowed between the first and second write; 0 disables the timeout.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port we_i, input, 1: write strobe.
REQ-007 SHALL have port wd_i, input, DW: write data.
REQ-008 SHALL have port re_i, input, 1: read strobe; aborts a staged write.
REQ-009 SHALL have port q_o, output, DW: committed value driving the datapath.
REQ-010 SHALL have port qe_o, output, 1: one-cycle pulse, high in the first cycle a new q_o is visible.
REQ-011 SHALL have port phase_o, output, 1: 1 while a first write is staged.
REQ-012 SHALL have port err_update_o, output, 1: one-cycle pulse on a mismatch or a timeout.
REQ-013 SHALL have port err_storage_o, output, 1: sticky storage-integrity alarm.

Function
REQ-014 SHALL hold four registers: state (IDLE/STAGED), staged[DW], committed[DW], shadow[DW] (stored inverted), plus a timeout counter.
REQ-015 IDLE with we_i: staged <= wd_i; state -> STAGED; counter <= 0; q_o unchanged.
REQ-016 STAGED with we_i and wd_i == staged: committed <= wd_i; shadow <= ~wd_i; state -> IDLE.
REQ-017 In the REQ-016 case, q_o SHALL show the new value and qe_o SHALL be high in the cycle after the second write (latency 1).
REQ-018 STAGED with we_i and wd_i != staged: committed unchanged; err_update_o pulses next cycle; state -> IDLE.
REQ-019 STAGED with re_i and no we_i: state -> IDLE; no error; committed unchanged.
REQ-020 we_i and re_i asserted in the same cycle: the write SHALL win and the read is ignored for sequencing.
REQ-021 STAGED with no we_i/re_i: counter increments.
REQ-022 If TIMEOUT>0 and the counter reaches TIMEOUT-1 with no we_i/re_i: state -> IDLE and err_update_o pulses next cycle.
REQ-023 A second write in the same cycle the counter reaches TIMEOUT-1 SHALL be processed normally (write wins over timeout).
REQ-024 The counter SHALL saturate and never wrap.
REQ-025 err_storage_o SHALL set in the cycle after committed != ~shadow is detected and SHALL remain set until reset.
REQ-026 While err_storage_o is set, we_i SHALL be ignored; q_o keeps the committed copy.
REQ-027 phase_o SHALL equal (state == STAGED), registered.
REQ-028 qe_o and err_update_o SHALL never be high in the same cycle.

Reset
REQ-029 rst_ni low at a clock edge SHALL set: committed = RESVAL, shadow = ~RESVAL, staged = RESVAL, state = IDLE, counter = 0, qe_o = 0, err_update_o = 0, err_storage_o = 0.
REQ-030 Reset asserted mid-sequence in STAGED SHALL discard the staged value without raising an error.
REQ-031 q_o SHALL equal RESVAL from the first cycle after reset.

Structure
REQ-032 Package ctrl_shadow_pkg SHALL hold the state enum, the packed ctrl_reg_t struct (force_zero_masks, manual_operation) and the constant CTRL_RESET.
REQ-033 The timeout counter SHALL be one sub-module, ctrl_shadow_timer (clear, enable, expired output).
REQ-034 The rest of the block SHALL be a single FSM with no combinational path from inputs to outputs.

Verification (DW=2, RESVAL=2'b10, TIMEOUT=8)
REQ-035 Reset release -> q_o=2'b10, phase_o=0, all flags 0.
REQ-036 Write 2'b01 twice in back-to-back cycles -> phase_o=1 after the first write; q_o=2'b01 and qe_o=1 exactly one cycle after the second write.
REQ-037 Write 2'b01 then 2'b11 -> err_update_o one-cycle pulse, q_o stays 2'b10, phase_o=0.
REQ-038 Write 2'b11, idle 8 cycles -> err_update_o pulse at the timeout; a further single write 2'b11 only stages (no commit).
REQ-039 Write 2'b11, re_i, then write 2'b11 -> no error, second write only stages; write with re_i in the same cycle still commits.
REQ-040 Bench forces shadow to 2'b00 while committed=2'b10 -> err_storage_o=1 next cycle; two writes of 2'b01 are ignored; only reset clears the flag.
